mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Responder and arbiter between the CPU's two memory initiators and the single byte-wide RAM port.
  - Initiators: the instruction-fetch port and the memory-stage data port.
- Accepts one word-level request at a time and serialises it into byte accesses on the RAM port.
- For reads, assembles the returned bytes little-endian into a 32-bit word and reports completion with a one-cycle done pulse.
- The data port has priority over instruction fetch.

Parameters:
- ADDR_W, 32, width of all address buses.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  instruction-fetch request; held until if_done or dropped to abort
- if_addr  in  ADDR_W  fetch byte address
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched word, little-endian
- dm_req  in  1  data request; held with operands until dm_done
- dm_wr  in  1  1 = store, 0 = load
- dm_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  32  store data; byte k = bits [8k+7:8k]
- dm_done  out  1  one-cycle pulse: access complete
- dm_rdata  out  32  load data, zero-extended; sign extension is done by the requester
- ram_din  in  8  RAM read byte; corresponds to ram_a of the previous cycle
- ram_dout  out  8  RAM write byte
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write enable

Behaviour:
- All outputs are registered.
- Reset values: ram_a=0, ram_dout=0, ram_wr=0, if_done=0, dm_done=0, if_data=0, dm_rdata=0; state=IDLE.
- Reset mid-operation: the operation is abandoned at the next edge, ram_wr drops, and no done is issued.
- Byte count N: 1 / 2 / 4 for dm_size 00 / 01 / (10 or 11). Instruction fetch always has N=4.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - If dm_req is high, latch the dm operands; else if if_req is high, latch the fetch.
  - Set byte counter k=0, go to ISSUE.
  - If neither request is high, ram_a=0, ram_wr=0, ram_dout=0.
  - Both requests high in the same cycle: dm wins; if_req waits.
- ISSUE (one cycle per byte):
  - Drive ram_a = base+k, computed mod 2^ADDR_W.
  - Store: ram_wr=1, ram_dout = wdata byte k.
  - Load: ram_wr=0.
  - After byte N-1: a store goes to DONE; a load goes to DRAIN.
- Read capture:
  - ram_din sampled in the cycle after address A+k was driven is written to byte lane k of the assembly register.
  - Lanes above N-1 are forced to 0.
- DRAIN: captures the last byte, sets ram_a=0 and ram_wr=0, goes to DONE.
- DONE:
  - Pulse the owning port's done for exactly one cycle with data valid.
  - ram_wr=0, ram_a=0.
  - New requests are not sampled in this cycle; return to IDLE.
  - The earliest next acceptance is the cycle after done.
- Timing (request first high in cycle 0 with the controller idle):
  - RAM addresses appear in cycles 1..N.
  - Store done in cycle N+1: SB=2, SH=3, SW=5.
  - Load done in cycle N+2: LB=3, LH=4, LW=6.
  - Fetch done in cycle 6.
  - Back-to-back requests therefore have an extra idle cycle after each done.
- Fetch abort:
  - If the controller is serving a fetch and if_req is low, it returns to IDLE at the next edge.
  - Effect: ram_a=0, no if_done, partial data discarded.
  - Data-port requests are never aborted.
- Addresses need not be aligned; consecutive byte addresses wrap at 2^ADDR_W.
- if_data and dm_rdata hold their last value between done pulses.

Test Plan:
- SW: addr=0x100, wdata=0xDEADBEEF.
  - Cycles 1-4: ram_wr=1; (ram_a, ram_dout) = (0x100,EF), (0x101,BE), (0x102,AD), (0x103,DE).
  - Cycle 5: dm_done=1, ram_wr=0.
- LW: addr=0x200, RAM holding 11 22 33 44.
  - dm_done in cycle 6 with dm_rdata=0x44332211.
  - LH at the same address: done in cycle 4, dm_rdata=0x00002211.
  - LB at 0x203: done in cycle 3, dm_rdata=0x00000044.
- Arbitration: if_req and dm_req both rise in cycle 0 (dm LB, fetch at 0x0).
  - dm served first, dm_done in cycle 3.
  - Fetch accepted in cycle 4, if_done in cycle 10.
- Fetch abort: if_req drops in cycle 3 of a fetch.
  - No if_done; ram_a=0 from cycle 4.
  - A dm_req asserted in cycle 4 is accepted in that cycle.
- Wrap: LW at 0xFFFFFFFE.
  - ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
  - Data assembled in that order.
- Reset: rst asserted in cycle 2 of an SW.
  - Next edge: ram_wr=0, ram_a=0, no dm_done.
  - Controller accepts a new request in the first cycle after rst deasserts.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bundle of the two CPU initiator ports and the byte-wide RAM port around mem_ctrl.
// slave = controller side, master = CPU/RAM side.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              dm_req;
  logic              dm_wr;
  logic [1:0]        dm_size;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_done;
  logic [31:0]       dm_rdata;

  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_size, dm_addr, dm_wdata, ram_din,
    output if_done, if_data, dm_done, dm_rdata, ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_size, dm_addr, dm_wdata, ram_din,
    input  if_done, if_data, dm_done, dm_rdata, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and data requests onto a byte-wide RAM, one byte per cycle, data port first.
// Store done at N+1, load/fetch done at N+2 cycles after acceptance; requests held until done.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic     clk,
  input logic     rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q;
  logic              own_dm_q;
  logic              wr_q;
  logic [2:0]        n_q;
  logic [2:0]        k_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;

  logic              cap_en;
  logic [1:0]        cap_lane;
  logic [31:0]       asm_d;
  logic              abort;

  function automatic logic [2:0] bytes_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // RAM data lags its address by one cycle: in ISSUE with k bytes sent, lane k-2 arrives.
  always_comb begin
    cap_en   = 1'b0;
    cap_lane = 2'd0;
    if (state_q == ISSUE && k_q >= 3'd2) begin
      cap_en   = 1'b1;
      cap_lane = 2'(k_q - 3'd2);
    end else if (state_q == DRAIN) begin
      cap_en   = 1'b1;
      cap_lane = 2'(n_q - 3'd1);
    end
    asm_d = asm_q;
    if (cap_en) begin
      asm_d[{cap_lane, 3'b000} +: 8] = bus.ram_din;
    end
  end

  assign abort = !own_dm_q && !bus.if_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      own_dm_q     <= 1'b0;
      wr_q         <= 1'b0;
      n_q          <= 3'd0;
      k_q          <= 3'd0;
      base_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      bus.ram_a    <= '0;
      bus.ram_dout <= '0;
      bus.ram_wr   <= 1'b0;
      bus.if_done  <= 1'b0;
      bus.dm_done  <= 1'b0;
      bus.if_data  <= '0;
      bus.dm_rdata <= '0;
    end else begin
      bus.if_done <= 1'b0;
      bus.dm_done <= 1'b0;
      case (state_q)
        IDLE: begin
          // Byte 0 is driven on the accepting edge so addresses appear in cycles 1..N.
          if (bus.dm_req) begin
            state_q      <= ISSUE;
            own_dm_q     <= 1'b1;
            wr_q         <= bus.dm_wr;
            n_q          <= bytes_of(bus.dm_size);
            k_q          <= 3'd1;
            base_q       <= bus.dm_addr;
            wdata_q      <= bus.dm_wdata;
            asm_q        <= '0;
            bus.ram_a    <= bus.dm_addr;
            bus.ram_wr   <= bus.dm_wr;
            bus.ram_dout <= bus.dm_wr ? bus.dm_wdata[7:0] : 8'h00;
          end else if (bus.if_req) begin
            state_q      <= ISSUE;
            own_dm_q     <= 1'b0;
            wr_q         <= 1'b0;
            n_q          <= 3'd4;
            k_q          <= 3'd1;
            base_q       <= bus.if_addr;
            asm_q        <= '0;
            bus.ram_a    <= bus.if_addr;
            bus.ram_wr   <= 1'b0;
            bus.ram_dout <= 8'h00;
          end else begin
            bus.ram_a    <= '0;
            bus.ram_wr   <= 1'b0;
            bus.ram_dout <= 8'h00;
          end
        end

        ISSUE: begin
          if (abort) begin
            state_q      <= IDLE;
            bus.ram_a    <= '0;
            bus.ram_wr   <= 1'b0;
            bus.ram_dout <= 8'h00;
          end else begin
            asm_q <= asm_d;
            if (k_q < n_q) begin
              k_q          <= k_q + 3'd1;
              bus.ram_a    <= base_q + ADDR_W'(k_q);
              bus.ram_wr   <= wr_q;
              bus.ram_dout <= wr_q ? wdata_q[{k_q[1:0], 3'b000} +: 8] : 8'h00;
            end else begin
              bus.ram_a    <= '0;
              bus.ram_wr   <= 1'b0;
              bus.ram_dout <= 8'h00;
              if (wr_q) begin
                state_q     <= DONE;
                bus.dm_done <= 1'b1;
              end else begin
                state_q <= DRAIN;
              end
            end
          end
        end

        DRAIN: begin
          bus.ram_a    <= '0;
          bus.ram_wr   <= 1'b0;
          bus.ram_dout <= 8'h00;
          if (abort) begin
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
            asm_q   <= asm_d;
            if (own_dm_q) begin
              bus.dm_done  <= 1'b1;
              bus.dm_rdata <= asm_d;
            end else begin
              bus.if_done <= 1'b1;
              bus.if_data <= asm_d;
            end
          end
        end

        default: begin
          // DONE: the pulse is visible now; requests are not sampled this cycle.
          state_q      <= IDLE;
          bus.ram_a    <= '0;
          bus.ram_wr   <= 1'b0;
          bus.ram_dout <= 8'h00;
        end
      endcase
    end
  end

endmodule
